mul_result_sequencer: RTL and testbench

Multicycle control and result stage wrapped around the datapath's combinational 32x32 signed Booth multiplier.
- Registers operands and holds them stable for a programmable settle window.
- Captures the 64-bit product into Z_HI/Z_LO.
- Streams the result onto the 32-bit internal bus, LO word first then HI, using a valid/ready handshake.
- Sits between the Y/bus operand sources and the HI/LO register writeback.

---
 rtl/mulseq_pkg.sv | 14 +
 rtl/mul_result_sequencer.sv | 109 ++++++++++
 tb/tb_mul_result_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mulseq_pkg.sv
// Shared types and constants for the multiplier result sequencer.
package mulseq_pkg;

  localparam int unsigned MULSEQ_DATA_W = 32;
  localparam int unsigned SETTLE_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } mulseq_state_e;

endpackage

// File: rtl/mul_result_sequencer.sv
// Operand register, settle timer and LO/HI result streamer around an external multiplier.
// Optional overflow flag output enabled by defining MULSEQ_OVF_FLAG_EN.
module mul_result_sequencer
  import mulseq_pkg::*;
#(
  parameter int unsigned DATA_W        = MULSEQ_DATA_W,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [DATA_W-1:0]   multiplicand_in,
  input  logic [DATA_W-1:0]   multiplier_in,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic [2*DATA_W-1:0] mul_product,
  output logic [DATA_W-1:0]   z_lo,
  output logic [DATA_W-1:0]   z_hi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_is_hi,
  output logic                busy,
  output logic                done
`ifdef MULSEQ_OVF_FLAG_EN
  ,
  output logic                ovf
`endif
);

  mulseq_state_e           state, state_next;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic                    accept;
  logic                    capture;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE:    if (start) begin
                 accept     = 1'b1;
                 state_next = EXEC;
               end
      EXEC:    if (settle_cnt == '0) begin
                 capture    = 1'b1;
                 state_next = SEND_LO;
               end
      SEND_LO: if (out_ready) state_next = SEND_HI;
      SEND_HI: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mul_a      <= '0;
      mul_b      <= '0;
      z_lo       <= '0;
      z_hi       <= '0;
      settle_cnt <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state == SEND_HI) && out_ready;
      if (accept) begin
        mul_a      <= multiplicand_in;
        mul_b      <= multiplier_in;
        settle_cnt <= SETTLE_CNT_W'(SETTLE_CYCLES - 1);
      end else if ((state == EXEC) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - SETTLE_CNT_W'(1);
      end
      if (capture) {z_hi, z_lo} <= mul_product;
    end
  end

  // Stream outputs decode registered state only, so out_ready never reaches out_valid.
  always_comb begin
    out_valid = 1'b0;
    out_is_hi = 1'b0;
    out_data  = '0;
    case (state)
      SEND_LO: begin
        out_valid = 1'b1;
        out_data  = z_lo;
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_is_hi = 1'b1;
        out_data  = z_hi;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef MULSEQ_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (clr || accept) ovf <= 1'b0;
    else if (capture)  ovf <= (mul_product[2*DATA_W-1:DATA_W] != {DATA_W{mul_product[DATA_W-1]}});
  end
`endif

endmodule

// File: tb/tb_mul_result_sequencer.sv
// Scoreboard bench for mul_result_sequencer: directed operands, queued expected words.
module tb_mul_result_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, start, out_ready;
  logic [31:0] multiplicand_in, multiplier_in;
  logic [31:0] mul_a, mul_b, z_lo, z_hi, out_data;
  logic [63:0] mul_product;
  logic        out_valid, out_is_hi, busy, done;

  logic        start_s;
  logic [31:0] ma_s, mb_s;
  logic [31:0] mul_a_s1, mul_b_s1, z_lo_s1, z_hi_s1, od_s1;
  logic [63:0] prod_s1;
  logic        ov_s1, oh_s1, busy_s1, done_s1;
  logic [31:0] mul_a_s15, mul_b_s15, z_lo_s15, z_hi_s15, od_s15;
  logic [63:0] p15;
  logic        ov_s15, oh_s15, busy_s15, done_s15;
`ifdef MULSEQ_OVF_FLAG_EN
  logic        ovf, ovf_s1, ovf_s15;
`endif

  // Behavioural stand-in for the sibling signed multiplier.
  assign mul_product = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
  assign prod_s1     = {{32{mul_a_s1[31]}}, mul_a_s1} * {{32{mul_b_s1[31]}}, mul_b_s1};

  mul_result_sequencer #(.DATA_W(32), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .clr(clr), .start(start),
    .multiplicand_in(multiplicand_in), .multiplier_in(multiplier_in),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .z_lo(z_lo), .z_hi(z_hi), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_is_hi(out_is_hi), .busy(busy), .done(done)
`ifdef MULSEQ_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  mul_result_sequencer #(.DATA_W(32), .SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .clr(clr), .start(start_s),
    .multiplicand_in(ma_s), .multiplier_in(mb_s),
    .mul_a(mul_a_s1), .mul_b(mul_b_s1), .mul_product(prod_s1),
    .z_lo(z_lo_s1), .z_hi(z_hi_s1), .out_valid(ov_s1), .out_ready(1'b1),
    .out_data(od_s1), .out_is_hi(oh_s1), .busy(busy_s1), .done(done_s1)
`ifdef MULSEQ_OVF_FLAG_EN
    , .ovf(ovf_s1)
`endif
  );

  mul_result_sequencer #(.DATA_W(32), .SETTLE_CYCLES(15)) dut_s15 (
    .clk(clk), .clr(clr), .start(start_s),
    .multiplicand_in(ma_s), .multiplier_in(mb_s),
    .mul_a(mul_a_s15), .mul_b(mul_b_s15), .mul_product(p15),
    .z_lo(z_lo_s15), .z_hi(z_hi_s15), .out_valid(ov_s15), .out_ready(1'b1),
    .out_data(od_s15), .out_is_hi(oh_s15), .busy(busy_s15), .done(done_s15)
`ifdef MULSEQ_OVF_FLAG_EN
    , .ovf(ovf_s15)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lo_edge = 0, hi_edge = 0, done_edge = 0;
  logic        exp_done = 1'b0;
  logic [32:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks the done pulse timing.
  always @(negedge clk) begin
    logic [32:0] e;
    chk("done_pulse", {63'd0, done}, {63'd0, exp_done});
    if (done === 1'b1) done_edge = cyc + 1;
    exp_done = out_valid && out_ready && out_is_hi && !clr;
    if (out_valid === 1'b1 && out_ready && !clr) begin
      if (out_is_hi) hi_edge = cyc + 1;
      else           lo_edge = cyc + 1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got is_hi=%b data=%h expected none", out_is_hi, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_word", {31'd0, out_is_hi, out_data}, {31'd0, e});
      end
    end
  end

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    multiplicand_in = a;
    multiplier_in   = b;
    start           = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", {63'd0, (busy || done)}, 64'd0);
  endtask

  task automatic wait_hi();
    int n = 0;
    while (!out_is_hi && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_hi_reached", {63'd0, out_is_hi}, 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
    chk({tag, "_z_lo"}, z_lo, 0);
    chk({tag, "_z_hi"}, z_hi, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_valid"}, {63'd0, out_valid}, 0);
    chk({tag, "_is_hi"}, {63'd0, out_is_hi}, 0);
    chk({tag, "_busy"}, {63'd0, busy}, 0);
    chk({tag, "_done"}, {63'd0, done}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    clr = 1'b1; start = 1'b0; out_ready = 1'b1;
    multiplicand_in = '0; multiplier_in = '0;
    start_s = 1'b0; ma_s = '0; mb_s = '0; p15 = '0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    chk_zero("reset");

    // 7 * -3 with minimum latency
    exp_q.push_back({1'b0, 32'hFFFF_FFEB});
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    do_start(32'd7, 32'hFFFF_FFFD);
    t0 = cyc;
    chk("exec_busy", {63'd0, busy}, 1);
    chk("exec_no_valid", {63'd0, out_valid}, 0);
    wait_idle();
    chk("lo_edge", lo_edge, t0 + 3);
    chk("hi_edge", hi_edge, t0 + 4);
    chk("done_edge", done_edge, t0 + 5);
    chk("z_lo_7x-3", z_lo, 32'hFFFF_FFEB);
    chk("z_hi_7x-3", z_hi, 32'hFFFF_FFFF);

    // most-negative squared, then a small product
    exp_q.push_back({1'b0, 32'h0000_0000});
    exp_q.push_back({1'b1, 32'h4000_0000});
    do_start(32'h8000_0000, 32'h8000_0000);
    wait_idle();
    chk("z_hi_minsq", z_hi, 32'h4000_0000);
`ifdef MULSEQ_OVF_FLAG_EN
    chk("ovf_set", {63'd0, ovf}, 1);
`endif
    exp_q.push_back({1'b0, 32'h0000_001E});
    exp_q.push_back({1'b1, 32'h0000_0000});
    do_start(32'd5, 32'd6);
`ifdef MULSEQ_OVF_FLAG_EN
    chk("ovf_clr_on_start", {63'd0, ovf}, 0);
`endif
    wait_idle();
`ifdef MULSEQ_OVF_FLAG_EN
    chk("ovf_small", {63'd0, ovf}, 0);
`endif

    // consumer stalls in SEND_LO
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_0051});
    exp_q.push_back({1'b1, 32'h0000_0000});
    do_start(32'd9, 32'd9);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, out_valid}, 1);
      chk("stall_data", out_data, 32'h0000_0051);
      chk("stall_is_hi", {63'd0, out_is_hi}, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();

    // start while busy is ignored; start in the done cycle is accepted
    exp_q.push_back({1'b0, 32'h0000_0006});
    exp_q.push_back({1'b1, 32'h0000_0000});
    do_start(32'd2, 32'd3);
    multiplicand_in = 32'd100; multiplier_in = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_mul_a", mul_a, 32'd2);
    chk("hold_mul_b", mul_b, 32'd3);
    wait_hi();
    multiplicand_in = 32'd11; multiplier_in = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    chk("done_cycle_idle", {63'd0, busy}, 0);
    exp_q.push_back({1'b0, 32'hFFFF_FFEC});
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    multiplicand_in = 32'hFFFF_FFFC; multiplier_in = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_busy", {63'd0, busy}, 1);
    chk("restart_mul_a", mul_a, 32'hFFFF_FFFC);
    wait_idle();

    // clr mid-operation
    do_start(32'd3, 32'd3);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk_zero("clr_exec");
    exp_q.push_back({1'b0, 32'h0000_0010});
    do_start(32'd4, 32'd4);
    wait_hi();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk_zero("clr_send_hi");
    exp_q.push_back({1'b0, 32'h0000_000C});
    exp_q.push_back({1'b1, 32'h0000_0000});
    do_start(32'd3, 32'd4);
    wait_idle();
    chk("z_lo_after_clr", z_lo, 32'h0000_000C);

    // settle window extremes: 1 and 15 cycles
    p15 = 64'h1111_2222_3333_4444;
    ma_s = 32'hFFFF_FFF9; mb_s = 32'd6; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    chk("s1_not_yet", z_lo_s1, 0);
    @(posedge clk); #1;
    chk("s1_z_lo", z_lo_s1, 32'hFFFF_FFD6);
    chk("s1_z_hi", z_hi_s1, 32'hFFFF_FFFF);
    repeat (13) @(posedge clk);
    #1;
    chk("s15_busy", {63'd0, busy_s15}, 1);
    chk("s15_not_early_lo", z_lo_s15, 0);
    chk("s15_not_early_hi", z_hi_s15, 0);
    p15 = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    chk("s15_z_lo", z_lo_s15, 32'h89AB_CDEF);
    chk("s15_z_hi", z_hi_s15, 32'h0123_4567);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
